uart_baud_gen: RTL and testbench

Parametrised fractional baud-rate generator for the UART. It produces an oversample tick, a mid-bit sample tick and a bit tick from a programmable divisor with a fractional part. Divisor updates are glitch-free and take effect on a tick boundary, and a restart input re-aligns the bit phase so the receiver can lock onto a start-bit edge. It feeds both the UART TX serializer (BitTick) and the RX sampler (OsTick/MidTick).

---
 rtl/uart_baud_gen.sv | 114 +++++++++++
 tb/tb_uart_baud_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator: oversample, mid-bit and bit ticks from a
// programmable D + F/2^FRAC_W divisor with tick-aligned, glitch-free updates.
module uart_baud_gen #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OSR        = 16,
    parameter int RESET_DIV  = 27,
    parameter int RESET_FRAC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DIV_W-1:0]  i_divisor,
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_load,
    input  logic              i_restart,
    output logic              o_os_tick,
    output logic              o_mid_tick,
    output logic              o_bit_tick,
    output logic              o_cfg_err
);

    localparam int OSC_W = $clog2(OSR);
    localparam logic [OSC_W-1:0] OSC_LAST = OSC_W'(OSR - 1);
    localparam logic [OSC_W-1:0] OSC_MID  = OSC_W'(OSR / 2 - 1);
    localparam logic [DIV_W:0]   CNT_ONE  = {{DIV_W{1'b0}}, 1'b1};

    logic [DIV_W-1:0]  r_ad;
    logic [FRAC_W-1:0] r_af;
    logic [DIV_W-1:0]  r_pd;
    logic [FRAC_W-1:0] r_pf;
    logic              r_pv;
    logic [DIV_W:0]    r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_lng;
    logic [OSC_W-1:0]  r_osc;

    logic [DIV_W:0]    w_period_m1;
    logic              w_hit;
    logic              w_cfg_err;
    logic              w_os;
    logic              w_imm;
    logic              w_apply;
    logic [FRAC_W-1:0] w_af_add;
    logic [FRAC_W:0]   w_acc_sum;

    always_comb begin
        w_cfg_err   = (r_ad < DIV_W'(2));
        w_period_m1 = ({1'b0, r_ad} + {{DIV_W{1'b0}}, r_lng}) - CNT_ONE;
        // >= rather than == so a shorter divisor applied mid-period (En low)
        // ends the current period on the next enabled cycle instead of wrapping.
        w_hit       = (r_cnt >= w_period_m1);
        w_os        = i_en & ~i_rst & ~w_cfg_err & ~i_restart & w_hit;
        w_imm       = ~i_en | w_cfg_err | i_restart;
        w_apply     = r_pv & (w_os | w_imm);
        // On the tick that swaps config in, the new fraction already drives
        // the carry, so the first new period follows the new fractional pattern.
        w_af_add    = (r_pv & w_os) ? r_pf : r_af;
        w_acc_sum   = {1'b0, r_acc} + {1'b0, w_af_add};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ad  <= DIV_W'(RESET_DIV);
            r_af  <= FRAC_W'(RESET_FRAC);
            r_pd  <= '0;
            r_pf  <= '0;
            r_pv  <= 1'b0;
            r_cnt <= '0;
            r_acc <= '0;
            r_lng <= 1'b0;
            r_osc <= '0;
        end else begin
            if (i_load && w_imm) begin
                r_ad <= i_divisor;
                r_af <= i_frac;
                r_pv <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_ad <= r_pd;
                    r_af <= r_pf;
                    r_pv <= 1'b0;
                end
                if (i_load) begin
                    r_pd <= i_divisor;
                    r_pf <= i_frac;
                    r_pv <= 1'b1;
                end
            end

            if (i_restart || w_cfg_err) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_lng <= 1'b0;
                r_osc <= '0;
            end else if (i_en) begin
                if (w_hit) begin
                    r_cnt <= '0;
                    r_acc <= w_acc_sum[FRAC_W-1:0];
                    r_lng <= w_acc_sum[FRAC_W];
                    r_osc <= (r_osc == OSC_LAST) ? '0 : r_osc + OSC_W'(1);
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    assign o_os_tick  = w_os;
    assign o_mid_tick = w_os & (r_osc == OSC_MID);
    assign o_bit_tick = w_os & (r_osc == OSC_LAST);
    assign o_cfg_err  = w_cfg_err;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: default rate, fractional divisor,
// enable gaps, restart alignment, config error recovery and reset.
module tb_uart_baud_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic [3:0]  frac;
    logic        load;
    logic        restart;
    logic        os, mid, bitt, cfg;
    logic        s_os, s_mid, s_bit, s_cfg;
    int          n_tests = 0;
    int          n_fail  = 0;

    uart_baud_gen #(
        .DIV_W(16), .FRAC_W(4), .OSR(16), .RESET_DIV(27), .RESET_FRAC(0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_divisor(div), .i_frac(frac),
        .i_load(load), .i_restart(restart),
        .o_os_tick(os), .o_mid_tick(mid), .o_bit_tick(bitt), .o_cfg_err(cfg)
    );

    always #5 clk = ~clk;

    // One clock: outputs sampled mid-cycle, inputs may change 1ns after the edge.
    task automatic cyc();
        @(negedge clk);
        s_os  = os;
        s_mid = mid;
        s_bit = bitt;
        s_cfg = cfg;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b0; restart = 1'b0; div = '0; frac = '0;
        cyc();
        n_tests++;
        if ({s_os, s_mid, s_bit} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ticks: got %b want 000", {s_os, s_mid, s_bit});
        end
        cyc();
        n_tests++;
        if (s_cfg !== 1'b0) begin
            n_fail++; $display("FAIL reset_cfg_err: got %b want 0", s_cfg);
        end
        rst = 1'b0;
    endtask

    task automatic test_default_rate();
        int q[$];
        int mid_n = 0, mid_at = -1, bit_n = 0, bit_at = -1, bad = 0, cfg_n = 0;
        int first;
        for (int i = 0; i < 432; i++) begin
            cyc();
            if (s_os) q.push_back(i);
            if (s_mid) begin mid_n++; mid_at = i; end
            if (s_bit) begin bit_n++; bit_at = i; end
            if (s_cfg) cfg_n++;
        end
        first = (q.size() > 0) ? q[0] : -1;
        n_tests++;
        if (first != 26) begin n_fail++; $display("FAIL default_first_os: got %0d want 26", first); end
        n_tests++;
        if (q.size() != 16) begin n_fail++; $display("FAIL default_os_count: got %0d want 16", q.size()); end
        foreach (q[k]) if (q[k] != 26 + 27 * k) bad++;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL default_os_spacing: got %0d off-grid ticks want 0", bad); end
        n_tests++;
        if (mid_n != 1 || mid_at != 215) begin
            n_fail++; $display("FAIL default_mid: got %0d ticks last at %0d want 1 at 215", mid_n, mid_at);
        end
        n_tests++;
        if (bit_n != 1 || bit_at != 431) begin
            n_fail++; $display("FAIL default_bit: got %0d ticks last at %0d want 1 at 431", bit_n, bit_at);
        end
        n_tests++;
        if (cfg_n != 0) begin n_fail++; $display("FAIL default_cfg_err: got %0d high cycles want 0", cfg_n); end
    endtask

    task automatic test_fractional();
        int q[$];
        int bad = 0, first, total;
        div = 16'd10; frac = 4'd8; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int i = 1; i < 1200 && q.size() < 65; i++) begin
            cyc();
            if (s_os) q.push_back(i);
        end
        n_tests++;
        if (q.size() != 65) begin n_fail++; $display("FAIL frac_tick_count: got %0d want 65", q.size()); end
        first = (q.size() > 0) ? q[0] : -1;
        n_tests++;
        if (first != 26) begin n_fail++; $display("FAIL frac_apply_tick: got %0d want 26", first); end
        for (int k = 1; k < q.size(); k++)
            if (q[k] - q[k-1] != ((k % 2 == 1) ? 10 : 11)) bad++;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL frac_periods: got %0d wrong periods want 0", bad); end
        total = (q.size() == 65) ? q[64] - q[0] : -1;
        n_tests++;
        if (total != 672) begin n_fail++; $display("FAIL frac_64_ticks: got %0d clocks want 672", total); end
    endtask

    task automatic test_en_gap();
        int q[$];
        int pre = 0, gap = 0, mid_idx = -1, bit_idx = -1, first, p1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (s_os) pre++;
        end
        en = 1'b0;
        for (int i = 9; i < 22; i++) begin
            cyc();
            if (s_os | s_mid | s_bit) gap++;
        end
        en = 1'b1;
        n_tests++;
        if (pre + gap != 0) begin n_fail++; $display("FAIL engap_quiet: got %0d ticks want 0", pre + gap); end
        for (int i = 22; i < 400 && q.size() < 15; i++) begin
            cyc();
            if (s_os) begin
                if (s_mid) mid_idx = q.size();
                if (s_bit) bit_idx = q.size();
                q.push_back(i);
            end
        end
        first = (q.size() > 0) ? q[0] : -1;
        p1    = (q.size() > 1) ? q[1] - q[0] : -1;
        n_tests++;
        if (first != 22) begin n_fail++; $display("FAIL engap_resume: got %0d want 22", first); end
        n_tests++;
        if (p1 != 11) begin n_fail++; $display("FAIL engap_frac_kept: got %0d want 11", p1); end
        n_tests++;
        if (mid_idx != 6 || bit_idx != 14) begin
            n_fail++; $display("FAIL engap_osc_kept: got mid %0d bit %0d want 6 14", mid_idx, bit_idx);
        end
    endtask

    task automatic test_restart();
        int q[$];
        int n = 0, pre = 0, mid_idx = -1, bit_idx = -1, first;
        for (int i = 0; i < 200 && n < 9; i++) begin
            cyc();
            if (s_os) n++;
        end
        n_tests++;
        if (n != 9) begin n_fail++; $display("FAIL restart_setup: got %0d ticks want 9", n); end
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (s_os) pre++;
        end
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        n_tests++;
        if ({s_os, s_mid, s_bit, pre[0]} !== 4'b0000 || pre != 0) begin
            n_fail++; $display("FAIL restart_drop: got ticks %b pre %0d want 000 0", {s_os, s_mid, s_bit}, pre);
        end
        for (int i = 1; i < 400 && q.size() < 16; i++) begin
            cyc();
            if (s_os) begin
                if (s_mid) mid_idx = q.size();
                if (s_bit) bit_idx = q.size();
                q.push_back(i);
            end
        end
        first = (q.size() > 0) ? q[0] : -1;
        n_tests++;
        if (first != 10) begin n_fail++; $display("FAIL restart_first: got %0d want 10", first); end
        n_tests++;
        if (mid_idx != 7 || bit_idx != 15) begin
            n_fail++; $display("FAIL restart_osc: got mid %0d bit %0d want 7 15", mid_idx, bit_idx);
        end

        q.delete();
        for (int i = 0; i < 3; i++) cyc();
        restart = 1'b1; load = 1'b1; div = 16'd8; frac = 4'd0;
        cyc();
        restart = 1'b0; load = 1'b0;
        for (int i = 1; i < 40 && q.size() < 2; i++) begin
            cyc();
            if (s_os) q.push_back(i);
        end
        n_tests++;
        if (q.size() != 2 || q[0] != 8 || q[1] != 16) begin
            n_fail++; $display("FAIL restart_load: got %0d ticks first %0d want 2 at 8,16",
                                q.size(), (q.size() > 0) ? q[0] : -1);
        end
    endtask

    task automatic test_mid_load();
        int q[$];
        restart = 1'b1; load = 1'b1; div = 16'd27; frac = 4'd0;
        cyc();
        restart = 1'b0; load = 1'b0;
        for (int i = 0; i < 100 && q.size() < 3; i++) begin
            if (i == 10) begin load = 1'b1; div = 16'd5; end
            cyc();
            load = 1'b0;
            if (s_os) q.push_back(i);
        end
        n_tests++;
        if (q.size() != 3 || q[0] != 26 || q[1] != 31 || q[2] != 36) begin
            n_fail++; $display("FAIL midload_ticks: got %0d ticks first %0d want 26,31,36",
                                q.size(), (q.size() > 0) ? q[0] : -1);
        end
    endtask

    task automatic test_cfg_err();
        int q[$];
        int cfg_at = -1, late = 0, cfg_hi = 0;
        load = 1'b1; div = 16'd1; frac = 4'd0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            load = 1'b0;
            if (s_cfg && cfg_at < 0) cfg_at = i;
            if (i >= 5 && (s_os | s_mid | s_bit)) late++;
        end
        n_tests++;
        if (cfg_at != 5) begin n_fail++; $display("FAIL cfgerr_rise: got %0d want 5", cfg_at); end
        n_tests++;
        if (late != 0) begin n_fail++; $display("FAIL cfgerr_quiet: got %0d ticks want 0", late); end
        load = 1'b1; div = 16'd4;
        cyc();
        load = 1'b0;
        n_tests++;
        if (s_cfg !== 1'b1) begin n_fail++; $display("FAIL cfgerr_load_cycle: got %b want 1", s_cfg); end
        for (int i = 0; i < 40 && q.size() < 4; i++) begin
            cyc();
            if (s_cfg) cfg_hi++;
            if (s_os) q.push_back(i);
        end
        n_tests++;
        if (cfg_hi != 0) begin n_fail++; $display("FAIL cfgerr_clear: got %0d high cycles want 0", cfg_hi); end
        n_tests++;
        if (q.size() != 4 || q[0] != 3 || q[3] != 15) begin
            n_fail++; $display("FAIL cfgerr_recover: got %0d ticks first %0d want 4 at 3..15",
                                q.size(), (q.size() > 0) ? q[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int q[$];
        load = 1'b1; div = 16'd9; frac = 4'd0;
        cyc();
        load = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 80 && q.size() < 2; i++) begin
            cyc();
            if (s_os) q.push_back(i);
        end
        n_tests++;
        if (q.size() != 2 || q[0] != 26 || q[1] != 53) begin
            n_fail++; $display("FAIL reset_mid_discard: got %0d ticks first %0d want 26,53",
                                q.size(), (q.size() > 0) ? q[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_fractional();
        test_en_gap();
        test_restart();
        test_mid_load();
        test_cfg_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
